// File: rtl/upscale_pkg.sv
// Shared constants and FSM state type for the 3x pixel upscaler.
package upscale_pkg;

  localparam int SCALE  = 3;
  localparam int HCNT_W = 2;

  localparam logic [HCNT_W-1:0] LAST_COPY = HCNT_W'(SCALE - 1);

  typedef enum logic [1:0] {
    FILL,
    RD,
    LOAD,
    HOLD
  } state_t;

  function automatic logic is_last_copy(input logic [HCNT_W-1:0] copy);
    return copy == LAST_COPY;
  endfunction

endpackage

// File: rtl/line_buffer_sdp.sv
// Simple dual-port line buffer: one write port, one registered read port (1-cycle latency).
module line_buffer_sdp #(
  parameter int PIX_W  = 8,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [PIX_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [PIX_W-1:0]  rd_data
);

  logic [PIX_W-1:0] mem [0:(1 << ADDR_W) - 1];
  logic [PIX_W-1:0] rd_data_reg;

  // No reset on storage or read register so the array maps onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/pixel_upscale_x3.sv
// Streaming 3x nearest-neighbour upscaler: each pixel emitted 3x, each line replayed 3x.
// Vertical replay and the line buffer exist only when UPSCALE_VERT_EN is defined.
module pixel_upscale_x3 import upscale_pkg::*; #(
  parameter int PIX_W    = 8,
  parameter int LINE_MAX = 160,
  parameter int ADDR_W   = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             in_sof,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_pixel,
  output logic             out_sof,
  output logic             out_last,
  output logic             err_overflow
);

`ifdef UPSCALE_VERT_EN
  localparam bit VERT_EN = 1'b1;
`else
  localparam bit VERT_EN = 1'b0;
`endif

  state_t            state_reg;
  logic [HCNT_W-1:0] hcnt_reg;
  logic [1:0]        vcnt_reg;
  logic [ADDR_W:0]   wr_addr_reg;
  logic [ADDR_W:0]   rd_addr_reg;
  logic [ADDR_W:0]   len_reg;
  logic              run_reg;
  logic              out_valid_reg;
  logic [PIX_W-1:0]  pix_reg;
  logic              last_reg;
  logic              sof_reg;
  logic              ovf_reg;
  logic [PIX_W-1:0]  rd_data;

  logic xfer;
  logic third;
  logic accept;
  logic at_limit;
  logic ovf_hit;

  assign xfer  = out_valid_reg && out_ready;
  assign third = xfer && is_last_copy(hcnt_reg);

  // A line-ending pixel must not let the next line in while a replay is about to start.
  assign in_ready = run_reg && (state_reg == FILL) &&
                    (!out_valid_reg || (third && !(VERT_EN && last_reg)));
  assign accept   = in_valid && in_ready;
  assign at_limit = (wr_addr_reg == (ADDR_W + 1)'(LINE_MAX - 1));
  assign ovf_hit  = VERT_EN && accept && at_limit && !in_last;

`ifdef UPSCALE_VERT_EN
  line_buffer_sdp #(
    .PIX_W  (PIX_W),
    .ADDR_W (ADDR_W)
  ) u_line_buffer (
    .clk     (clk),
    .wr_en   (accept),
    .wr_addr (wr_addr_reg[ADDR_W-1:0]),
    .wr_data (in_pixel),
    .rd_en   (state_reg == RD),
    .rd_addr (rd_addr_reg[ADDR_W-1:0]),
    .rd_data (rd_data)
  );
`else
  assign rd_data = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= FILL;
      hcnt_reg      <= '0;
      vcnt_reg      <= '0;
      wr_addr_reg   <= '0;
      rd_addr_reg   <= '0;
      len_reg       <= '0;
      run_reg       <= 1'b0;
      out_valid_reg <= 1'b0;
      pix_reg       <= '0;
      last_reg      <= 1'b0;
      sof_reg       <= 1'b0;
      ovf_reg       <= 1'b0;
    end else begin
      run_reg <= 1'b1;
      if (ovf_hit) begin
        ovf_reg <= 1'b1;
      end

      case (state_reg)
        FILL: begin
          if (accept) begin
            // Covers the simultaneous third-copy/new-pixel case: the new pixel starts at copy 0.
            out_valid_reg <= 1'b1;
            pix_reg       <= in_pixel;
            last_reg      <= in_last || ovf_hit;
            sof_reg       <= in_sof;
            hcnt_reg      <= '0;
            wr_addr_reg   <= VERT_EN ? wr_addr_reg + 1'b1 : '0;
          end else if (third) begin
            hcnt_reg      <= '0;
            out_valid_reg <= 1'b0;
            if (VERT_EN && last_reg) begin
              len_reg     <= wr_addr_reg;
              vcnt_reg    <= vcnt_reg + 1'b1;
              rd_addr_reg <= '0;
              state_reg   <= RD;
            end
          end else if (xfer) begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end

        RD: begin
          state_reg <= LOAD;
        end

        LOAD: begin
          out_valid_reg <= 1'b1;
          pix_reg       <= rd_data;
          hcnt_reg      <= '0;
          sof_reg       <= 1'b0;
          last_reg      <= (rd_addr_reg == len_reg - 1'b1);
          rd_addr_reg   <= rd_addr_reg + 1'b1;
          state_reg     <= HOLD;
        end

        HOLD: begin
          if (third) begin
            hcnt_reg      <= '0;
            out_valid_reg <= 1'b0;
            if (!last_reg) begin
              state_reg <= RD;
            end else if (vcnt_reg == 2'd2) begin
              vcnt_reg    <= '0;
              wr_addr_reg <= '0;
              state_reg   <= FILL;
            end else begin
              vcnt_reg    <= vcnt_reg + 1'b1;
              rd_addr_reg <= '0;
              state_reg   <= RD;
            end
          end else if (xfer) begin
            hcnt_reg <= hcnt_reg + 1'b1;
          end
        end

        default: begin
          state_reg <= FILL;
        end
      endcase
    end
  end

  assign out_valid    = out_valid_reg;
  assign out_pixel    = pix_reg;
  assign out_last     = last_reg && is_last_copy(hcnt_reg);
  assign out_sof      = sof_reg && (hcnt_reg == '0) && (vcnt_reg == 2'd0);
  assign err_overflow = VERT_EN ? ovf_reg : 1'b0;

endmodule

// File: tb/tb_pixel_upscale_x3.sv
// Directed self-checking bench for pixel_upscale_x3 (both UPSCALE_VERT_EN builds).
module tb_pixel_upscale_x3;

  localparam int LM = 4;
`ifdef UPSCALE_VERT_EN
  localparam int ROWS = 3;
`else
  localparam int ROWS = 1;
`endif
  localparam int RST_STOP = (ROWS == 3) ? 14 : 2;

  typedef struct {
    logic [7:0] px;
    logic       sof;
    logic       last;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_pixel = 8'h00;
  logic       in_sof = 1'b0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_pixel;
  logic       out_sof;
  logic       out_last;
  logic       err_overflow;

  int tests = 0;
  int fails = 0;

  beat_t      got[$];
  beat_t      exp_q[$];
  logic [7:0] line_px[16];
  bit         line_sof[16];
  bit         line_last[16];
  int         line_n;
  bit         acc;
  bit         stall_prev;
  beat_t      stall_beat;
  int         last_cycles;

  pixel_upscale_x3 #(
    .PIX_W    (8),
    .LINE_MAX (LM),
    .ADDR_W   (2)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_pixel     (in_pixel),
    .in_sof       (in_sof),
    .in_last      (in_last),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_pixel    (out_pixel),
    .out_sof      (out_sof),
    .out_last     (out_last),
    .err_overflow (err_overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    tests++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Sample on the falling edge, then step past the rising edge.
  task automatic tick();
    @(negedge clk);
    if (stall_prev) begin
      chk("stall_valid", out_valid, 1);
      chk("stall_pixel", out_pixel, stall_beat.px);
      chk("stall_sof", out_sof, stall_beat.sof);
      chk("stall_last", out_last, stall_beat.last);
    end
    stall_prev = out_valid && !out_ready;
    stall_beat = '{out_pixel, out_sof, out_last};
    if (out_valid && out_ready) got.push_back('{out_pixel, out_sof, out_last});
    acc = in_valid && in_ready;
    @(posedge clk);
    #1;
  endtask

  task automatic set_line(input int n, input logic [7:0] base, input logic [7:0] step,
                          input int last_a, input int last_b, input bit sof);
    line_n = n;
    for (int i = 0; i < 16; i++) begin
      line_px[i]   = base + 8'(i) * step;
      line_sof[i]  = sof && (i == 0);
      line_last[i] = (i == last_a) || (i == last_b);
    end
  endtask

  task automatic run_line(input int exp_beats, input bit toggle, input int budget, input int stop_beats);
    int idx;
    int cyc;
    bit done;
    idx = 0;
    cyc = 0;
    done = 1'b0;
    got.delete();
    while (cyc < budget && !done) begin
      in_valid  = (idx < line_n);
      in_pixel  = (idx < line_n) ? line_px[idx] : 8'h00;
      in_sof    = (idx < line_n) && line_sof[idx];
      in_last   = (idx < line_n) && line_last[idx];
      out_ready = toggle ? (cyc % 2 == 0) : 1'b1;
      tick();
      if (acc) idx++;
      cyc++;
      if (stop_beats > 0) done = (got.size() >= stop_beats);
      else done = (idx >= line_n) && (got.size() >= exp_beats);
    end
    in_valid = 1'b0;
    in_sof = 1'b0;
    in_last = 1'b0;
    out_ready = 1'b1;
    last_cycles = cyc;
    chk("cycle_budget", done, 1);
  endtask

  // Drain a few idle cycles so any extra (duplicated) beat is caught.
  task automatic drain();
    for (int i = 0; i < 8; i++) tick();
  endtask

  task automatic build_expected();
    int s;
    exp_q.delete();
    s = 0;
    for (int i = 0; i < line_n; i++) begin
      if (line_last[i] || (ROWS == 3 && (i - s + 1) == LM)) begin
        for (int r = 0; r < ROWS; r++)
          for (int j = s; j <= i; j++)
            for (int c = 0; c < 3; c++)
              exp_q.push_back('{line_px[j], line_sof[j] && r == 0 && c == 0, j == i && c == 2});
        s = i + 1;
      end
    end
  endtask

  task automatic compare(input string tag);
    build_expected();
    chk({tag, "_count"}, got.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < got.size(); k++) begin
      chk($sformatf("%s_px[%0d]", tag, k), got[k].px, exp_q[k].px);
      chk($sformatf("%s_sof[%0d]", tag, k), got[k].sof, exp_q[k].sof);
      chk($sformatf("%s_last[%0d]", tag, k), got[k].last, exp_q[k].last);
    end
  endtask

  function automatic beat_t beat_at(input int k);
    beat_t b;
    b = '{8'h00, 1'b0, 1'b0};
    if (k < got.size()) b = got[k];
    return b;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stall_prev = 1'b0;
    // Reset state, sampled while rst_n is held low.
    #12;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_pixel", out_pixel, 0);
    chk("rst_out_sof", out_sof, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_err", err_overflow, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();

    // Line 0x55,0x66 with sof, out_ready held high.
    set_line(2, 8'h55, 8'h11, 1, 99, 1'b1);
    run_line(6 * ROWS, 1'b0, 400, 0);
    drain();
    compare("line56");
    chk("line56_b0_px", beat_at(0).px, 8'h55);
    chk("line56_b0_sof", beat_at(0).sof, 1);
    chk("line56_b1_sof", beat_at(1).sof, 0);
    chk("line56_b2_last", beat_at(2).last, 0);
    chk("line56_b5_px", beat_at(5).px, 8'h66);
    chk("line56_b5_last", beat_at(5).last, 1);

    // Two back-to-back lines with in_valid held high.
    set_line(4, 8'h11, 8'h11, 1, 3, 1'b0);
    run_line(12 * ROWS, 1'b0, 400, 0);
`ifndef UPSCALE_VERT_EN
    chk("b2b_cycles", last_cycles, 13);
`endif
    drain();
    compare("b2b");

    // Line 0x11..0x44, out_ready high, then the same line with out_ready toggling.
    set_line(4, 8'h11, 8'h11, 3, 99, 1'b1);
    run_line(12 * ROWS, 1'b0, 400, 0);
    drain();
    compare("line4");
    chk("line4_b11_last", beat_at(11).last, 1);
    chk("line4_b11_px", beat_at(11).px, 8'h44);
`ifdef UPSCALE_VERT_EN
    chk("line4_b12_px", beat_at(12).px, 8'h11);
    chk("line4_b12_sof", beat_at(12).sof, 0);
    chk("line4_b23_last", beat_at(23).last, 1);
    chk("line4_b35_last", beat_at(35).last, 1);
`endif
    run_line(12 * ROWS, 1'b1, 400, 0);
    drain();
    compare("line4_stall");

    // Reset in the middle of output (row 2 replay in the vertical build).
    set_line(2, 8'h77, 8'h11, 1, 99, 1'b0);
    run_line(0, 1'b0, 400, RST_STOP);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_out_pixel", out_pixel, 0);
    chk("midrst_out_last", out_last, 0);
    chk("midrst_out_sof", out_sof, 0);
    chk("midrst_in_ready", in_ready, 0);
    stall_prev = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    set_line(2, 8'hA0, 8'h01, 1, 99, 1'b0);
    run_line(6 * ROWS, 1'b0, 400, 0);
    drain();
    compare("after_rst");
    chk("after_rst_b0_px", beat_at(0).px, 8'hA0);

    // Six-pixel line against a four-pixel line limit.
    set_line(6, 8'h01, 8'h01, 5, 99, 1'b0);
    run_line((ROWS == 3) ? 54 : 18, 1'b0, 600, 0);
    drain();
    compare("ovf");
    chk("ovf_err", err_overflow, (ROWS == 3) ? 1 : 0);
    chk("idle_in_ready", in_ready, 1);
    chk("idle_out_valid", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
